// File: rtl/mem_req_sched.sv
// Memory request scheduler: round-robin arbitration of icache/dcache/store ports onto one memory channel,
// with TID allocation and response routing. Optional build macro MEM_SCHED_STORE_PRIO_EN gives stores priority.
module mem_req_sched #(
  parameter int AddrWidth            = 64,
  parameter int DataWidth            = 64,
  parameter int TidWidth             = 2,
  parameter int MaxOutstandingStores = 7,
  parameter int NrReq                = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NrReq-1:0]           req_valid_i,
  output logic [NrReq-1:0]           req_ready_o,
  input  logic [NrReq*AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0]       req_wdata_i,
  input  logic [DataWidth/8-1:0]     req_be_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [AddrWidth-1:0]       mem_req_addr_o,
  output logic                       mem_req_we_o,
  output logic [DataWidth-1:0]       mem_req_wdata_o,
  output logic [DataWidth/8-1:0]     mem_req_be_o,
  output logic [TidWidth-1:0]        mem_req_tid_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [TidWidth-1:0]        mem_rsp_tid_i,
  output logic [NrReq-1:0]           rsp_valid_o,
  input  logic                       drain_i,
  output logic                       drain_done_o,
  output logic                       tid_err_o
);

  localparam int NrTags   = 1 << TidWidth;
  localparam int CntWidth = $clog2(MaxOutstandingStores + 1);

  logic [NrTags-1:0]   live;
  logic [1:0]          src [NrTags];
  logic [CntWidth-1:0] store_cnt;
  logic [1:0]          rr_ptr;

  logic                free_found;
  logic [TidWidth-1:0] free_tag;
  logic                base_ok;
  logic [NrReq-1:0]    eligible;
  logic [NrReq-1:0]    grant;
  logic [1:0]          winner;
  logic                grant_any;
  logic                rsp_hit;
  logic [1:0]          rsp_src;
  logic                store_inc;
  logic                store_dec;

  // Lowest-index free tag; responses this cycle do not free a tag until the edge.
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int i = NrTags - 1; i >= 0; i--) begin
      if (!live[i]) begin
        free_found = 1'b1;
        free_tag   = TidWidth'(i);
      end
    end
  end

  assign base_ok     = !rst_i && free_found && !drain_i && (!mem_req_valid_o || mem_req_ready_i);
  assign eligible[0] = req_valid_i[0] && base_ok;
  assign eligible[1] = req_valid_i[1] && base_ok;
  assign eligible[2] = req_valid_i[2] && base_ok && (store_cnt < CntWidth'(MaxOutstandingStores));

  always_comb begin
    grant  = '0;
    winner = 2'd0;
`ifdef MEM_SCHED_STORE_PRIO_EN
    if (eligible[2]) begin
      winner = 2'd2;
    end else if (rr_ptr == 2'd0) begin
      winner = eligible[0] ? 2'd0 : 2'd1;
    end else begin
      winner = eligible[1] ? 2'd1 : 2'd0;
    end
`else
    // Scanning backwards leaves the first eligible port at or after rr_ptr.
    for (int i = NrReq - 1; i >= 0; i--) begin
      if (eligible[(int'(rr_ptr) + i) % NrReq]) begin
        winner = 2'((int'(rr_ptr) + i) % NrReq);
      end
    end
`endif
    if (|eligible) begin
      grant[winner] = 1'b1;
    end
  end

  assign req_ready_o  = grant;
  assign grant_any    = |grant;
  assign rsp_hit      = mem_rsp_valid_i && live[mem_rsp_tid_i];
  assign rsp_src      = src[mem_rsp_tid_i];
  assign store_inc    = grant[2];
  assign store_dec    = rsp_hit && (rsp_src == 2'd2);
  assign drain_done_o = !rst_i && drain_i && !(|live) && !mem_req_valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live            <= '0;
      for (int i = 0; i < NrTags; i++) src[i] <= 2'd0;
      store_cnt       <= '0;
      rr_ptr          <= 2'd0;
      rsp_valid_o     <= '0;
      tid_err_o       <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_we_o    <= 1'b0;
      mem_req_wdata_o <= '0;
      mem_req_be_o    <= '0;
      mem_req_tid_o   <= '0;
    end else begin
      rsp_valid_o <= '0;
      if (rsp_hit) begin
        rsp_valid_o[rsp_src] <= 1'b1;
        live[mem_rsp_tid_i]  <= 1'b0;
      end else if (mem_rsp_valid_i) begin
        tid_err_o <= 1'b1;
      end

      if (grant_any) begin
        live[free_tag]  <= 1'b1;
        src[free_tag]   <= winner;
        mem_req_valid_o <= 1'b1;
        mem_req_addr_o  <= req_addr_i[winner*AddrWidth +: AddrWidth];
        mem_req_we_o    <= (winner == 2'd2);
        mem_req_wdata_o <= (winner == 2'd2) ? req_wdata_i : '0;
        mem_req_be_o    <= (winner == 2'd2) ? req_be_i : '0;
        mem_req_tid_o   <= free_tag;
`ifdef MEM_SCHED_STORE_PRIO_EN
        if (winner != 2'd2) rr_ptr <= (winner == 2'd0) ? 2'd1 : 2'd0;
`else
        rr_ptr <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
`endif
      end else if (mem_req_ready_i) begin
        mem_req_valid_o <= 1'b0;
      end

      if (store_inc && !store_dec) begin
        store_cnt <= store_cnt + 1'b1;
      end else if (!store_inc && store_dec) begin
        store_cnt <= store_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed self-checking bench for mem_req_sched (4 tags, store limit 3 so both stall causes are reachable).
module tb_mem_req_sched;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 2;
  localparam int MS = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [2:0]      req_valid_i;
  logic [2:0]      req_ready_o;
  logic [3*AW-1:0] req_addr_i;
  logic [DW-1:0]   req_wdata_i;
  logic [DW/8-1:0] req_be_i;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [AW-1:0]   mem_req_addr_o;
  logic            mem_req_we_o;
  logic [DW-1:0]   mem_req_wdata_o;
  logic [DW/8-1:0] mem_req_be_o;
  logic [TW-1:0]   mem_req_tid_o;
  logic            mem_rsp_valid_i;
  logic [TW-1:0]   mem_rsp_tid_i;
  logic [2:0]      rsp_valid_o;
  logic            drain_i;
  logic            drain_done_o;
  logic            tid_err_o;

  int vec_count  = 0;
  int miss_count = 0;
  int ord1 [3];
  int ord6 [4];
  int own  [4];
  logic [63:0] addr_tab [6];

  mem_req_sched #(
    .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstandingStores(MS), .NrReq(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o), .mem_req_tid_o(mem_req_tid_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_tid_i(mem_rsp_tid_i), .rsp_valid_o(rsp_valid_o),
    .drain_i(drain_i), .drain_done_o(drain_done_o), .tid_err_o(tid_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid);
    req_valid_i = valid;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_addr(input int port, input logic [63:0] value);
    req_addr_i[port*AW +: AW] = value;
  endtask

  function automatic logic [2:0] onehot(input int p);
    logic [2:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  task automatic respond(input int tid, input int owner);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_tid_i   = TW'(tid);
    tick();
    mem_rsp_valid_i = 1'b0;
    checkOutput("rsp_route", 64'(rsp_valid_o), 64'(onehot(owner)));
  endtask

  initial begin
    logic [2:0] vmask;
`ifdef MEM_SCHED_STORE_PRIO_EN
    ord1 = '{2, 0, 1};
    ord6 = '{2, 2, 2, 0};
`else
    ord1 = '{0, 1, 2};
    ord6 = '{0, 1, 2, 0};
`endif
    addr_tab = '{64'h1000_0000_0000_0040, 64'h2000_0000_0000_0080, 64'h3000_0000_0000_00c0,
                 64'h4000_0000_0000_0100, 64'h5000_0000_0000_0140, 64'h6000_0000_0000_0180};
    rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0; mem_req_ready_i = 1'b1;
    req_wdata_i = 64'hdead_beef_cafe_f00d; req_be_i = 8'hf0;
    mem_rsp_valid_i = 1'b0; mem_rsp_tid_i = '0; drain_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    checkOutput("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("rst_tid_err", 64'(tid_err_o), 64'd0);
    checkOutput("rst_drain_done", 64'(drain_done_o), 64'd0);

    // Three simultaneous requests issue back-to-back with TIDs 0..2.
    for (int p = 0; p < 3; p++) set_addr(p, addr_tab[p]);
    vmask = 3'b111;
    applyStimulus(vmask);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t1_ready", 64'(req_ready_o), 64'(onehot(ord1[k])));
      tick();
      checkOutput("t1_valid", 64'(mem_req_valid_o), 64'd1);
      checkOutput("t1_addr", mem_req_addr_o, addr_tab[ord1[k]]);
      checkOutput("t1_tid", 64'(mem_req_tid_o), 64'(k));
      checkOutput("t1_we", 64'(mem_req_we_o), 64'(ord1[k] == 2));
      checkOutput("t1_wdata", mem_req_wdata_o, (ord1[k] == 2) ? 64'hdead_beef_cafe_f00d : 64'd0);
      checkOutput("t1_be", 64'(mem_req_be_o), (ord1[k] == 2) ? 64'hf0 : 64'd0);
      vmask = vmask & ~onehot(ord1[k]);
      applyStimulus(vmask);
    end
    tick();
    checkOutput("t1_idle", 64'(mem_req_valid_o), 64'd0);

    // Fourth load takes the last tag; the fifth waits for a response.
    set_addr(1, addr_tab[3]);
    applyStimulus(3'b010);
    checkOutput("t2_ready4", 64'(req_ready_o), 64'b010);
    tick();
    checkOutput("t2_tid4", 64'(mem_req_tid_o), 64'd3);
    checkOutput("t2_addr4", mem_req_addr_o, addr_tab[3]);
    set_addr(1, addr_tab[4]);
    #1;
    checkOutput("t2_stall", 64'(req_ready_o), 64'd0);
    tick();
    checkOutput("t2_stall_hold", 64'(req_ready_o), 64'd0);
    checkOutput("t2_drained_out", 64'(mem_req_valid_o), 64'd0);
    mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd2;
    #1;
    checkOutput("t2_no_same_cycle_reuse", 64'(req_ready_o), 64'd0);
    tick();
    mem_rsp_valid_i = 1'b0;
    checkOutput("t2_rsp", 64'(rsp_valid_o), 64'(onehot(ord1[2])));
    #1;
    checkOutput("t2_ready5", 64'(req_ready_o), 64'b010);
    tick();
    checkOutput("t2_tid5", 64'(mem_req_tid_o), 64'd2);
    checkOutput("t2_addr5", mem_req_addr_o, addr_tab[4]);
    applyStimulus(3'b000);
    tick();
    own = '{ord1[0], ord1[1], 1, 1};
    for (int t = 0; t < 4; t++) respond(t, own[t]);

    // Store limit: three stores issue, the fourth waits although tag 3 is free.
    applyStimulus(3'b100);
    for (int k = 0; k < MS; k++) begin
      checkOutput("t3_ready", 64'(req_ready_o), 64'b100);
      tick();
      checkOutput("t3_tid", 64'(mem_req_tid_o), 64'(k));
      checkOutput("t3_we", 64'(mem_req_we_o), 64'd1);
    end
    checkOutput("t3_limit", 64'(req_ready_o), 64'd0);
    tick();
    checkOutput("t3_limit_hold", 64'(req_ready_o), 64'd0);
    mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd1;
    #1;
    checkOutput("t3_limit_rsp_cycle", 64'(req_ready_o), 64'd0);
    tick();
    mem_rsp_valid_i = 1'b0;
    checkOutput("t3_rsp", 64'(rsp_valid_o), 64'b100);
    #1;
    checkOutput("t3_ready_after_rsp", 64'(req_ready_o), 64'b100);
    tick();
    checkOutput("t3_tid_reuse", 64'(mem_req_tid_o), 64'd1);

    // Back-pressure: the loaded store stays put and nothing else is granted.
    mem_req_ready_i = 1'b0;
    set_addr(0, addr_tab[5]);
    applyStimulus(3'b001);
    checkOutput("t4_blocked", 64'(req_ready_o), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("t4_hold_valid", 64'(mem_req_valid_o), 64'd1);
      checkOutput("t4_hold_addr", mem_req_addr_o, addr_tab[2]);
      checkOutput("t4_hold_tid", 64'(mem_req_tid_o), 64'd1);
      checkOutput("t4_hold_data", mem_req_wdata_o, 64'hdead_beef_cafe_f00d);
      checkOutput("t4_hold_ready", 64'(req_ready_o), 64'd0);
    end
    mem_req_ready_i = 1'b1;
    #1;
    checkOutput("t4_release", 64'(req_ready_o), 64'b001);
    tick();
    checkOutput("t4_next_tid", 64'(mem_req_tid_o), 64'd3);
    checkOutput("t4_next_addr", mem_req_addr_o, addr_tab[5]);
    checkOutput("t4_next_wdata", mem_req_wdata_o, 64'd0);
    applyStimulus(3'b000);
    tick();
    checkOutput("t4_idle", 64'(mem_req_valid_o), 64'd0);

    // Drain with two live tags, then a stray response sets the sticky error.
    respond(0, 2);
    respond(1, 2);
    drain_i = 1'b1;
    applyStimulus(3'b011);
    checkOutput("t5_drain_block", 64'(req_ready_o), 64'd0);
    checkOutput("t5_not_done", 64'(drain_done_o), 64'd0);
    respond(2, 2);
    checkOutput("t5_one_live", 64'(drain_done_o), 64'd0);
    checkOutput("t5_drain_block2", 64'(req_ready_o), 64'd0);
    respond(3, 0);
    checkOutput("t5_done", 64'(drain_done_o), 64'd1);
    applyStimulus(3'b000);
    drain_i = 1'b0;
    #1;
    checkOutput("t5_done_drop", 64'(drain_done_o), 64'd0);
    mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd3;
    tick();
    mem_rsp_valid_i = 1'b0;
    checkOutput("t5_no_strobe", 64'(rsp_valid_o), 64'd0);
    checkOutput("t5_tid_err", 64'(tid_err_o), 64'd1);
    tick(); tick();
    checkOutput("t5_tid_err_sticky", 64'(tid_err_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("t5_tid_err_reset", 64'(tid_err_o), 64'd0);

    // All ports held valid: arbitration order until tags run out, then one load frees a tag.
    for (int p = 0; p < 3; p++) set_addr(p, addr_tab[p]);
    applyStimulus(3'b111);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t6_ready", 64'(req_ready_o), 64'(onehot(ord6[k])));
      tick();
      checkOutput("t6_tid", 64'(mem_req_tid_o), 64'(k));
      checkOutput("t6_addr", mem_req_addr_o, addr_tab[ord6[k]]);
    end
    checkOutput("t6_full", 64'(req_ready_o), 64'd0);
    respond(3, 0);
    #1;
    checkOutput("t6_rr_next", 64'(req_ready_o), 64'b010);
    tick();
    checkOutput("t6_rr_tid", 64'(mem_req_tid_o), 64'd3);
    applyStimulus(3'b000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/mem_req_sched.md
Name: mem_req_sched

Overview:
Memory request scheduler between the fetch/data caches and the single downstream memory request channel. Arbitrates three requesters: port 0 icache refill read, port 1 dcache load read, port 2 write-buffer store. Allocates a transaction ID (TID) per issued request and routes responses back by TID. Enforces the outstanding-store limit and provides a drain handshake used by fence/flush sequencing.

Parameters:
AddrWidth, 64, request address width
DataWidth, 64, store data width
TidWidth, 2, TID width; 2**TidWidth tags
MaxOutstandingStores, 7, max stores issued and not yet acknowledged
NrReq, 3, number of requesters (fixed at 3; port roles as in Overview)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NrReq  per-port request valid
req_ready_o  out  NrReq  per-port request accepted this cycle
req_addr_i  in  NrReq*AddrWidth  per-port address, port n at [n*AddrWidth +: AddrWidth]
req_wdata_i  in  DataWidth  store data (port 2 only)
req_be_i  in  DataWidth/8  store byte enables (port 2 only)
mem_req_valid_o  out  1  downstream request valid
mem_req_ready_i  in  1  downstream accepts
mem_req_addr_o  out  AddrWidth  downstream address
mem_req_we_o  out  1  1 = store
mem_req_wdata_o  out  DataWidth  store data
mem_req_be_o  out  DataWidth/8  byte enables
mem_req_tid_o  out  TidWidth  allocated TID
mem_rsp_valid_i  in  1  downstream response valid (always accepted)
mem_rsp_tid_i  in  TidWidth  response TID
rsp_valid_o  out  NrReq  one-hot response strobe to owning port
drain_i  in  1  stop issuing; request drain
drain_done_o  out  1  drain_i high, no tags live, output register empty
tid_err_o  out  1  sticky: response for unallocated TID

Behaviour:
- Reset (rst_i sampled high at clk edge): all outputs 0; tag table cleared; store counter 0; RR pointer = port 0; tid_err_o cleared.
- Tag table: 2**TidWidth entries {live, src[1:0]}. Free tag = lowest-index non-live entry.
- Eligibility: port n eligible if req_valid_i[n], free tag exists, drain_i low, output register empty or emptying this cycle (mem_req_ready_i & mem_req_valid_o). Port 2 additionally requires store counter < MaxOutstandingStores.
- Arbitration: round-robin among eligible ports starting at RR pointer; winner gets req_ready_o=1 for exactly one cycle; RR pointer <- winner+1 mod NrReq. At most one req_ready_o per cycle.
- Issue: grant loads the output register next edge: mem_req_valid_o=1, fields from winner, we=1 iff winner is port 2, tid = allocated tag; tag marked live with src. Latency req handshake -> mem_req_valid_o: 1 cycle. Back-to-back issue allowed (full throughput while mem_req_ready_i=1).
- Output held stable while mem_req_valid_o & !mem_req_ready_i; clears when accepted with no new grant.
- Store counter: +1 on port-2 grant, -1 on response whose tag src=2; both same cycle -> unchanged. Never exceeds MaxOutstandingStores.
- Response: mem_rsp_valid_i with live tag -> rsp_valid_o[src]=1 next cycle (registered), tag freed same edge; freed tag allocatable the cycle after response. Response to non-live tag -> no strobe, tid_err_o=1 until reset.
- Response and allocation same cycle: allocation uses tags free before the response.
- Drain: drain_i blocks new grants same cycle (combinational gate); drain_done_o=1 when drain_i & no live tags & !mem_req_valid_o; drops same cycle drain_i drops.
- req_wdata_i/req_be_i ignored for ports 0/1; mem_req_wdata_o/be_o = 0 on loads.
- Requester may drop req_valid_i before ready; no grant results.

Optional Feature:
MEM_SCHED_STORE_PRIO_EN: when defined, eligible port 2 wins over ports 0/1 regardless of RR pointer; RR applies between ports 0/1 only and pointer advances only on their grants. When undefined, plain 3-way round-robin as above.

Test Plan:
- Reset then ports 0,1,2 all valid, mem_req_ready_i=1 -> grants in order 0,1,2 on consecutive cycles, TIDs 0,1,2, mem_req_we_o=0,0,1.
- 4 loads issued, no responses -> 5th request stalls (req_ready_o=0); response TID 2 -> rsp_valid_o to owner next cycle, stalled request gets TID 2 the cycle after.
- TidWidth=3, MaxOutstandingStores=7, port 2 only, no responses -> 7 grants then stall; one store response -> 8th store granted.
- mem_req_ready_i=0 for 5 cycles with request loaded -> addr/tid/data stable, no further req_ready_o; ready=1 -> accepted once.
- drain_i=1 with 2 live tags -> no grants, drain_done_o=0 until both responses, then 1; response with non-live TID 3 -> tid_err_o=1 sticky until rst_i.
- MEM_SCHED_STORE_PRIO_EN defined, all ports continuously valid -> port 2 granted every eligible cycle until store limit, then 0/1 alternate.
